// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction memory and its byte-stream loader.
// Loader FSM state encoding, the default NOP word and the header length.
package inst_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  // RISC-V "addi x0, x0, 0"
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  // Header is a little-endian word count, one byte per header state
  localparam int HDR_LEN = 2;

  // States in which the loader accepts bytes
  function automatic logic is_loading(state_t s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/inst_mem_ram.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared, so a reset or reload keeps old words.
module inst_mem_ram
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  // Write a completed word
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_mem.sv
// Instruction memory with a byte-stream loader that holds the CPU in reset
// until a program has been loaded.
// Optional feature: define INST_MEM_CHECKSUM_EN to expect a trailing XOR
// checksum byte after the data; a mismatch parks the loader in ERR.
//
// state | meaning
// IDLE  | leaving reset, go to LEN0 next cycle
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte
// DATA  | receiving program bytes, little-endian words
// CSUM  | waiting for checksum byte (checksum build only)
// DONE  | program loaded, CPU released, fetches served
// ERR   | checksum mismatch, CPU held in reset
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  output logic        ld_ready_o,
  input  logic        ld_restart_i,
  output logic        cpu_rst_o,
  output logic        err_o,
  output logic [15:0] words_o
);

  localparam int CNT_W = HDR_LEN * 8;

`ifdef INST_MEM_CHECKSUM_EN
  localparam state_t LP_FINAL = ST_CSUM;
`else
  localparam state_t LP_FINAL = ST_DONE;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_words;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_lo;

  logic               w_ready;
  logic               w_restart;
  logic               w_hs;
  logic               w_word_done;
  logic               w_last_word;
  logic               w_count_zero;
  logic               w_in_range;
  logic               w_we;
  logic [31:0]        w_wdata;
  logic [31:0]        w_rdata;
  logic               w_addr_ok;

  assign w_ready      = is_loading(r_state);
  assign w_restart    = ld_restart_i && (r_state != ST_IDLE);
  // A byte offered together with a restart is dropped
  assign w_hs         = ld_valid_i && w_ready && !ld_restart_i;
  assign w_word_done  = w_hs && (r_state == ST_DATA) && (r_byte_cnt == 2'd3);
  assign w_last_word  = ((r_words + 16'd1) == r_count);
  assign w_count_zero = ({ld_data_i, r_count[7:0]} == '0);
  // Words beyond the array are consumed and counted but not stored
  assign w_in_range   = ((r_words >> ADDR_W) == 16'd0);
  assign w_we         = w_word_done && w_in_range;
  assign w_wdata      = {ld_data_i, r_lo};

`ifdef INST_MEM_CHECKSUM_EN
  logic [7:0] r_csum;
  logic       r_err;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and CPU reset decode
  always_comb begin
    w_state_nxt = r_state;
    cpu_rst_o   = 1'b1;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_LEN0;
      ST_LEN0: if (w_hs) w_state_nxt = ST_LEN1;
      ST_LEN1: if (w_hs) w_state_nxt = w_count_zero ? LP_FINAL : ST_DATA;
      ST_DATA: if (w_word_done && w_last_word) w_state_nxt = LP_FINAL;
`ifdef INST_MEM_CHECKSUM_EN
      ST_CSUM: if (w_hs) w_state_nxt = (ld_data_i == r_csum) ? ST_DONE : ST_ERR;
`endif
      ST_DONE: cpu_rst_o = 1'b0;
      ST_ERR:  w_state_nxt = ST_ERR;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_restart) w_state_nxt = ST_LEN0;
  end

  // Loader datapath: header count, byte assembly, word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_words    <= '0;
      r_byte_cnt <= '0;
      r_lo       <= '0;
    end else if (w_restart) begin
      r_words    <= '0;
      r_byte_cnt <= '0;
    end else if (w_hs) begin
      case (r_state)
        ST_LEN0: r_count[7:0]  <= ld_data_i;
        ST_LEN1: r_count[15:8] <= ld_data_i;
        ST_DATA: begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          r_lo       <= {ld_data_i, r_lo[23:8]};
          if (r_byte_cnt == 2'd3) r_words <= r_words + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef INST_MEM_CHECKSUM_EN
  // Running XOR of data bytes and checksum verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (w_restart) begin
      r_csum <= '0;
      r_err  <= 1'b0;
    end else if (w_hs) begin
      if (r_state == ST_DATA) r_csum <= r_csum ^ ld_data_i;
      if (r_state == ST_CSUM) r_err  <= (ld_data_i != r_csum);
    end
  end
  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  inst_mem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_words[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (inst_addr_i[ADDR_W+1:2]),
    .o_rdata (w_rdata)
  );

  // Fetches outside the array or before the load completes see a NOP
  assign w_addr_ok  = ((inst_addr_i >> (ADDR_W + 2)) == 32'd0);
  assign inst_o     = (inst_ce_i && (r_state == ST_DONE) && w_addr_ok) ? w_rdata : NOP_WORD;
  assign ld_ready_o = w_ready;
  assign words_o    = r_words;

endmodule

// File: tb/tb_inst_mem.sv
// Bench for inst_mem: two instances (ADDR_W=10 and ADDR_W=2) share one
// loader stream; expectations are queued and checked by a monitor.
`timescale 1ns/1ps
module tb_inst_mem;
  import inst_mem_pkg::*;

  localparam int K_INST_A  = 0;
  localparam int K_INST_B  = 1;
  localparam int K_CPURST  = 2;
  localparam int K_READY   = 3;
  localparam int K_ERR     = 4;
  localparam int K_WORDS_A = 5;
  localparam int K_WORDS_B = 6;
  localparam int K_STATE   = 7;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_ce = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = '0;
  logic        ld_restart = 1'b0;

  logic [31:0] inst_a, inst_b;
  logic        ready_a, ready_b, cpu_rst_a, cpu_rst_b, err_a, err_b;
  logic [15:0] words_a, words_b;

  chk_t        sb_q[$];
  logic        chk_strobe = 1'b0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  model_csum = '0;

  always #5 clk = ~clk;

  inst_mem #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst_a),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(ready_a), .ld_restart_i(ld_restart),
    .cpu_rst_o(cpu_rst_a), .err_o(err_a), .words_o(words_a)
  );

  inst_mem #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .inst_ce_i(inst_ce), .inst_addr_i(inst_addr), .inst_o(inst_b),
    .ld_valid_i(ld_valid), .ld_data_i(ld_data), .ld_ready_o(ready_b), .ld_restart_i(ld_restart),
    .cpu_rst_o(cpu_rst_b), .err_o(err_b), .words_o(words_b)
  );

  // Monitor: compare all queued expectations when the strobe is up
  always @(negedge clk) begin
    chk_t        c;
    logic [31:0] act;
    if (chk_strobe) begin
      while (sb_q.size() > 0) begin
        c = sb_q.pop_front();
        case (c.kind)
          K_INST_A:  act = inst_a;
          K_INST_B:  act = inst_b;
          K_CPURST:  act = {30'b0, cpu_rst_a, cpu_rst_b};
          K_READY:   act = {30'b0, ready_a, ready_b};
          K_ERR:     act = {30'b0, err_a, err_b};
          K_WORDS_A: act = {16'b0, words_a};
          K_WORDS_B: act = {16'b0, words_b};
          default:   act = {29'b0, dut_a.r_state};
        endcase
        n_tests++;
        if (act !== c.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, expected 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] v, input string nm);
    logic [31:0] e;
    e = v;
    if (kind == K_CPURST || kind == K_READY || kind == K_ERR) e = {30'b0, v[0], v[0]};
    sb_q.push_back('{kind, e, nm});
  endtask

  // Hand the queue to the monitor; returns at posedge + 1
  task automatic flush();
    chk_strobe = 1'b1;
    @(negedge clk);
    #1 chk_strobe = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic ce, input logic [31:0] ea,
                       input logic [31:0] eb, input string nm);
    inst_addr = addr;
    inst_ce   = ce;
    expect_val(K_INST_A, ea, {nm, "_a"});
    expect_val(K_INST_B, eb, {nm, "_b"});
    flush();
  endtask

  // Offer one byte until accepted; called and returns at posedge + 1
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    forever begin
      @(negedge clk);
      if (ready_a) break;
      n++;
      if (n > 50) begin
        n_tests++;
        n_fail++;
        $display("FAIL ld_ready_timeout: got 0, expected 1");
        break;
      end
    end
    @(posedge clk);
    #1 ld_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] cnt);
    model_csum = '0;
    send_byte(cnt[7:0]);
    send_byte(cnt[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      model_csum = model_csum ^ w[8*b +: 8];
      send_byte(w[8*b +: 8]);
    end
  endtask

  task automatic send_csum();
`ifdef INST_MEM_CHECKSUM_EN
    send_byte(model_csum);
`endif
  endtask

  task automatic restart(input logic with_byte, input logic [7:0] b);
    ld_restart = 1'b1;
    ld_valid   = with_byte;
    ld_data    = b;
    @(posedge clk);
    #1;
    ld_restart = 1'b0;
    ld_valid   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    expect_val(K_STATE,   32'(ST_IDLE), "rst_state");
    expect_val(K_CPURST,  1, "rst_cpu_rst");
    expect_val(K_READY,   0, "rst_ready");
    expect_val(K_ERR,     0, "rst_err");
    expect_val(K_WORDS_A, 0, "rst_words");
    flush();
    rst = 1'b1;
    @(posedge clk);
    #1;
    expect_val(K_STATE, 32'(ST_LEN0), "len0_after_idle");
    expect_val(K_READY, 1, "len0_ready");
    flush();

    // Two-word program
    send_hdr(16'd2);
    send_word(32'h0000_0013);
    expect_val(K_STATE,   32'(ST_DATA), "mid_state");
    expect_val(K_WORDS_A, 1, "mid_words");
    expect_val(K_CPURST,  1, "mid_cpu_rst");
    flush();
    fetch(32'h0, 1'b1, 32'h13, 32'h13, "fetch_before_done");
    send_word(32'h0010_0093);
    send_csum();
    expect_val(K_CPURST,  0, "done_cpu_rst");
    expect_val(K_READY,   0, "done_ready");
    expect_val(K_WORDS_A, 2, "done_words");
    expect_val(K_ERR,     0, "done_err");
    flush();
    fetch(32'h4,    1'b1, 32'h0010_0093, 32'h0010_0093, "fetch_w1");
    fetch(32'h0,    1'b1, 32'h0000_0013, 32'h0000_0013, "fetch_w0");
    fetch(32'h7,    1'b1, 32'h0010_0093, 32'h0010_0093, "fetch_low_bits");
    fetch(32'h4,    1'b0, 32'h13, 32'h13, "fetch_ce0");
    fetch(32'h1000, 1'b1, 32'h13, 32'h13, "fetch_oob");

    // Empty program, memory retained
    restart(1'b0, 8'h00);
    expect_val(K_STATE, 32'(ST_LEN0), "restart_len0");
    flush();
    send_hdr(16'd0);
    send_csum();
    expect_val(K_STATE,   32'(ST_DONE), "cnt0_state");
    expect_val(K_CPURST,  0, "cnt0_cpu_rst");
    expect_val(K_WORDS_A, 0, "cnt0_words");
    flush();
    fetch(32'h4, 1'b1, 32'h0010_0093, 32'h0010_0093, "cnt0_retained");

    // Five words: the ADDR_W=2 instance drops the fifth
    restart(1'b0, 8'h00);
    send_hdr(16'd5);
    for (int i = 1; i <= 5; i++) send_word(32'hA000_0000 | 32'(i));
    send_csum();
    expect_val(K_WORDS_A, 5, "cnt5_words_a");
    expect_val(K_WORDS_B, 5, "cnt5_words_b");
    expect_val(K_CPURST,  0, "cnt5_cpu_rst");
    flush();
    fetch(32'h10, 1'b1, 32'hA000_0005, 32'h0000_0013, "cnt5_fetch_10");
    fetch(32'hC,  1'b1, 32'hA000_0004, 32'hA000_0004, "cnt5_fetch_c");

    // Reset in the middle of a word
    restart(1'b0, 8'h00);
    send_hdr(16'd1);
    send_byte(8'hEE);
    send_byte(8'hFF);
    #2 rst = 1'b0;
    expect_val(K_STATE,   32'(ST_IDLE), "midrst_state");
    expect_val(K_CPURST,  1, "midrst_cpu_rst");
    expect_val(K_READY,   0, "midrst_ready");
    expect_val(K_WORDS_A, 0, "midrst_words");
    flush();
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_hdr(16'd0);
    send_csum();
    fetch(32'h0, 1'b1, 32'hA000_0001, 32'hA000_0001, "midrst_mem_kept");

    // Restart during DATA drops the concurrent byte
    restart(1'b0, 8'h00);
    send_hdr(16'd1);
    send_byte(8'h55);
    restart(1'b1, 8'h77);
    expect_val(K_STATE,   32'(ST_LEN0), "data_restart_state");
    expect_val(K_WORDS_A, 0, "data_restart_words");
    flush();
    send_hdr(16'd1);
    send_word(32'h8765_4321);
    send_csum();
    expect_val(K_WORDS_A, 1, "reload_words");
    expect_val(K_STATE,   32'(ST_DONE), "reload_state");
    flush();
    fetch(32'h0, 1'b1, 32'h8765_4321, 32'h8765_4321, "reload_w0");
    fetch(32'h4, 1'b1, 32'hA000_0002, 32'hA000_0002, "reload_w1_kept");

`ifdef INST_MEM_CHECKSUM_EN
    // Bad then good checksum
    restart(1'b0, 8'h00);
    send_hdr(16'd1);
    send_word(32'hDDCC_BBAA);
    send_byte(8'h01);
    expect_val(K_STATE,  32'(ST_ERR), "csum_bad_state");
    expect_val(K_ERR,    1, "csum_bad_err");
    expect_val(K_CPURST, 1, "csum_bad_cpu_rst");
    expect_val(K_READY,  0, "csum_bad_ready");
    flush();
    restart(1'b0, 8'h00);
    expect_val(K_ERR, 0, "csum_restart_err");
    flush();
    send_hdr(16'd1);
    send_word(32'hDDCC_BBAA);
    send_byte(8'h00);
    expect_val(K_STATE, 32'(ST_DONE), "csum_good_state");
    expect_val(K_ERR,   0, "csum_good_err");
    flush();
    fetch(32'h0, 1'b1, 32'hDDCC_BBAA, 32'hDDCC_BBAA, "csum_good_w0");
`else
    expect_val(K_ERR, 0, "err_tied_low");
    flush();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
